// File: rtl/led_pkg.sv
// Shared mode/state encodings and the one-hot helper for the LED mode sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BREATH = 2'd1,
    MODE_HORSE  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BLANK = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] m);
    onehot4 = 4'b0001 << m;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key synchroniser + debouncer; key_press is a one-cycle pulse
// arriving DB_CYC+2 cycles after the key settles low. No backpressure.
module key_debounce #(
  parameter int DB_CYC = 1000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_press
);

  localparam int CW = $clog2(DB_CYC + 1);

  logic          key_s1_q, key_s2_q;
  logic          lvl_q, lvl_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count only while the synced level disagrees; any bounce back clears it.
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (key_s2_q != lvl_q) begin
      if (cnt_q == CW'(DB_CYC - 1)) begin
        lvl_d   = key_s2_q;
        press_d = lvl_q & ~key_s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      lvl_q    <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign key_press = press_q;

endmodule

// File: rtl/led_mode_seq.sv
// Picks the pattern engine driving the LEDs; every mode change is a dark gap of
// BLANK_CYC cycles, a one-cycle engine clear, then a one-cycle LOAD. No backpressure.
module led_mode_seq
  import led_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int BLANK_MS    = 10,
  parameter int DWELL_MS    = 2000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [1:0] sw,
  input  logic       key_n,
  input  logic [7:0] pat0,
  input  logic [7:0] pat1,
  input  logic [7:0] pat2,
  input  logic [7:0] pat3,
  output logic [3:0] eng_en,
  output logic [3:0] eng_clr,
  output logic [7:0] led_out,
  output logic [1:0] cur_mode,
  output logic       auto_on,
  output logic       busy
);

  localparam int MS_CYC    = CLK_FREQ / 1000;
  localparam int DB_CYC    = MS_CYC * DEBOUNCE_MS;
  localparam int BLANK_CYC = MS_CYC * BLANK_MS;
  localparam int DWELL_CYC = MS_CYC * DWELL_MS;
  localparam int BW        = $clog2(BLANK_CYC + 1);
  localparam int WW        = $clog2(DWELL_CYC + 1);

  state_e        state_q, state_d;
  logic [1:0]    sw_s1_q, sw_s2_q;
  logic [1:0]    cur_mode_q, cur_mode_d;
  logic [1:0]    nxt_mode_q, nxt_mode_d;
  logic [7:0]    led_out_q, led_out_d;
  logic          auto_on_q, auto_on_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [WW-1:0] dwell_q, dwell_d;
  logic          key_press;
  logic          sw_req, blank_last;
  logic [1:0]    target;
  logic [7:0]    pat_sel;

  key_debounce #(.DB_CYC(DB_CYC)) u_key_debounce (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .key_n    (key_n),
    .key_press(key_press)
  );

  assign target     = auto_on_q ? cur_mode_q + 2'd1 : sw_s2_q;
  assign sw_req     = auto_on_q ? (dwell_q == WW'(DWELL_CYC - 1)) : (sw_s2_q != cur_mode_q);
  assign blank_last = (blank_q == BW'(BLANK_CYC - 1));

  always_comb begin
    case (cur_mode_q)
      2'd0:    pat_sel = pat0;
      2'd1:    pat_sel = pat1;
      2'd2:    pat_sel = pat2;
      default: pat_sel = pat3;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (sw_req) state_d = ST_BLANK;
      ST_BLANK: if (blank_last) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // The key toggles auto mode in any state; an in-flight switch still completes.
  always_comb begin
    led_out_d  = '0;
    dwell_d    = '0;
    blank_d    = '0;
    cur_mode_d = cur_mode_q;
    nxt_mode_d = nxt_mode_q;
    auto_on_d  = auto_on_q ^ key_press;
    eng_en     = '0;
    eng_clr    = '0;
    case (state_q)
      ST_RUN: begin
        eng_en = onehot4(cur_mode_q);
        if (sw_req) begin
          nxt_mode_d = target;
        end else begin
          led_out_d = pat_sel;
          dwell_d   = auto_on_q ? dwell_q + WW'(1) : '0;
        end
      end
      ST_BLANK: begin
        if (blank_last) begin
          eng_clr    = onehot4(nxt_mode_q);
          cur_mode_d = nxt_mode_q;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      ST_LOAD: begin
        eng_en    = onehot4(cur_mode_q);
        led_out_d = pat_sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q    <= 2'd0;
      sw_s2_q    <= 2'd0;
      cur_mode_q <= MODE_OFF;
      nxt_mode_q <= MODE_OFF;
      led_out_q  <= '0;
      auto_on_q  <= 1'b0;
      blank_q    <= '0;
      dwell_q    <= '0;
    end else begin
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      cur_mode_q <= cur_mode_d;
      nxt_mode_q <= nxt_mode_d;
      led_out_q  <= led_out_d;
      auto_on_q  <= auto_on_d;
      blank_q    <= blank_d;
      dwell_q    <= dwell_d;
    end
  end

  assign led_out  = led_out_q;
  assign cur_mode = cur_mode_q;
  assign auto_on  = auto_on_q;
  assign busy     = (state_q != ST_RUN);

endmodule

// File: tb/tb_led_mode_seq.sv
// Directed bench for led_mode_seq at 50 cycles/ms; engine-clear pulses are
// checked against a queue of expected one-hot values.
module tb_led_mode_seq;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [1:0] sw;
  logic       key_n;
  logic [7:0] pat0, pat1, pat2, pat3;
  logic [3:0] eng_en, eng_clr;
  logic [7:0] led_out;
  logic [1:0] cur_mode;
  logic       auto_on, busy;

  int         n_asrt = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         toggles = 0;
  logic       auto_prev = 1'b0;
  logic [3:0] clr_q[$];
  int         t1, t2, t3, t4;

  led_mode_seq #(
    .CLK_FREQ   (50_000),
    .DEBOUNCE_MS(20),
    .BLANK_MS   (10),
    .DWELL_MS   (100)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .key_n   (key_n),
    .pat0    (pat0),
    .pat1    (pat1),
    .pat2    (pat2),
    .pat3    (pat3),
    .eng_en  (eng_en),
    .eng_clr (eng_clr),
    .led_out (led_out),
    .cur_mode(cur_mode),
    .auto_on (auto_on),
    .busy    (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_mode(input logic [1:0] m, input int budget, input string tag);
    int n = 0;
    while (cur_mode !== m && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, cur_mode, m);
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (auto_on !== auto_prev) toggles <= toggles + 1;
    auto_prev <= auto_on;
    if (eng_clr !== 4'b0000) begin
      if (clr_q.size() == 0) chk("eng_clr_unexpected", eng_clr, 0);
      else                   chk("eng_clr_pulse", eng_clr, clr_q.pop_front());
    end
  end

  initial begin
    pat0 = 8'h00; pat1 = 8'h3C; pat2 = 8'hA5; pat3 = 8'h81;
    sw = 2'd0; key_n = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_led", led_out, 8'h00);
    chk("rst_eng_en", eng_en, 4'b0001);
    chk("rst_eng_clr", eng_clr, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mode", cur_mode, 2'd0);
    chk("rst_auto", auto_on, 1'b0);
    step(3);
    rst_n = 1'b1;
    step(20);
    chk("idle_led", led_out, 8'h00);
    chk("idle_eng_en", eng_en, 4'b0001);
    chk("idle_busy", busy, 1'b0);

    // Manual switch 0 -> 2 with exact cycle positions.
    sw = 2'd2;
    clr_q.push_back(4'b0100);
    step(2);
    chk("sw2_busy_p2", busy, 1'b0);
    step(1);
    chk("sw2_busy_p3", busy, 1'b1);
    chk("sw2_led_p3", led_out, 8'h00);
    chk("sw2_en_p3", eng_en, 4'b0000);
    step(498);
    chk("sw2_clr_p501", eng_clr, 4'b0000);
    step(1);
    chk("sw2_clr_p502", eng_clr, 4'b0100);
    chk("sw2_mode_p502", cur_mode, 2'd0);
    step(1);
    chk("sw2_en_p503", eng_en, 4'b0100);
    chk("sw2_mode_p503", cur_mode, 2'd2);
    chk("sw2_led_p503", led_out, 8'h00);
    step(1);
    chk("sw2_led_p504", led_out, 8'hA5);
    chk("sw2_busy_p504", busy, 1'b0);
    pat2 = 8'h5A;
    step(1);
    chk("pat_follow", led_out, 8'h5A);
    pat2 = 8'hA5;
    step(1);

    // sw 2 -> 1 -> 2 inside the blank window.
    sw = 2'd1;
    clr_q.push_back(4'b0010);
    clr_q.push_back(4'b0100);
    step(103);
    chk("sw121_busy", busy, 1'b1);
    sw = 2'd2;
    wait_mode(2'd1, 600, "sw121_mode1");
    wait_mode(2'd2, 1200, "sw121_mode2");
    step(600);
    chk("sw121_settled_mode", cur_mode, 2'd2);
    chk("sw121_settled_busy", busy, 1'b0);
    chk("sw121_settled_led", led_out, 8'hA5);

    sw = 2'd0;
    clr_q.push_back(4'b0001);
    wait_mode(2'd0, 1200, "back_to0");
    step(5);
    chk("back_to0_busy", busy, 1'b0);

    // Bouncy key, then a real press enabling auto-rotate.
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b0;
      step(100);
      key_n = 1'b1;
      step(100);
    end
    chk("bounce_toggles", toggles, 0);
    chk("bounce_auto", auto_on, 1'b0);
    key_n = 1'b0;
    step(1200);
    chk("press_auto", auto_on, 1'b1);
    chk("press_toggles", toggles, 1);
    key_n = 1'b1;

    clr_q.push_back(4'b0010);
    wait_mode(2'd1, 7000, "auto_mode1");
    t1 = cyc;
    step(2);
    chk("auto_led1", led_out, 8'h3C);
    clr_q.push_back(4'b0100);
    wait_mode(2'd2, 6000, "auto_mode2");
    t2 = cyc;
    chk("auto_period_12", t2 - t1, 5501);
    clr_q.push_back(4'b1000);
    wait_mode(2'd3, 6000, "auto_mode3");
    t3 = cyc;
    chk("auto_period_23", t3 - t2, 5501);
    clr_q.push_back(4'b0001);
    wait_mode(2'd0, 6000, "auto_mode0");
    t4 = cyc;
    chk("auto_period_30", t4 - t3, 5501);

    // Short press must be ignored.
    key_n = 1'b0;
    step(800);
    key_n = 1'b1;
    step(1100);
    chk("short_auto", auto_on, 1'b1);
    chk("short_toggles", toggles, 1);

    // Leave auto with sw != cur_mode: switch follows right away.
    sw = 2'd3;
    clr_q.push_back(4'b1000);
    key_n = 1'b0;
    step(1200);
    chk("leave_auto", auto_on, 1'b0);
    chk("leave_toggles", toggles, 2);
    key_n = 1'b1;
    wait_mode(2'd3, 1000, "leave_mode3");
    step(5);
    chk("leave_busy", busy, 1'b0);
    chk("leave_eng_en", eng_en, 4'b1000);

    // Reset in the middle of a blank.
    sw = 2'd1;
    step(3);
    chk("mid_blank_busy", busy, 1'b1);
    step(100);
    rst_n = 1'b0;
    #1;
    chk("midrst_led", led_out, 8'h00);
    chk("midrst_eng_en", eng_en, 4'b0001);
    chk("midrst_eng_clr", eng_clr, 4'b0000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mode", cur_mode, 2'd0);
    chk("midrst_auto", auto_on, 1'b0);
    sw = 2'd3;
    step(4);
    rst_n = 1'b1;
    clr_q.push_back(4'b1000);
    step(2);
    chk("rel_busy_p2", busy, 1'b0);
    step(1);
    chk("rel_busy_p3", busy, 1'b1);
    chk("rel_led_p3", led_out, 8'h00);
    wait_mode(2'd3, 1000, "rel_mode3");
    step(2);
    chk("rel_led_final", led_out, 8'h81);
    chk("rel_eng_en_final", eng_en, 4'b1000);

    step(10);
    chk("clr_queue_empty", clr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/led_mode_seq.md
# led_mode_seq

Mode sequencer for the LED display path. It owns the choice of which pattern engine (off, breath, horse, blink) drives the 8 LEDs, and sequences every change with a blanking gap and a one-shot engine clear. The mode source is either the 2-bit switch or an internal auto-rotate timer, toggled by a debounced push key. It sits between the board inputs and the pattern engines, and registers the final `led_out`.

## Interface
- `CLK_FREQ`, 50_000_000: clock cycles per second. Benches use 50_000, so 1 ms = 50 cycles.
- `DEBOUNCE_MS`, 20: key stable time.
- `BLANK_MS`, 10: dark gap between modes.
- `DWELL_MS`, 2000: time per mode in auto-rotate.
- `sys_clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `sw` input 2: manual mode select, asynchronous.
- `key_n` input 1: push key, active-low, asynchronous, bouncy.
- `pat0`..`pat3` input 8 each: engine patterns for modes 0..3.
- `eng_en` output 4: one-hot run enable to the engine of the current mode.
- `eng_clr` output 4: one-cycle one-hot clear to the incoming engine.
- `led_out` output 8: registered LED drive.
- `cur_mode` output 2: active mode.
- `auto_on` output 1: auto-rotate active.
- `busy` output 1: high while a mode change is in progress.

## Operation
- Derived constants:
  - `MS_CYC = CLK_FREQ/1000`
  - `DB_CYC = MS_CYC*DEBOUNCE_MS`
  - `BLANK_CYC = MS_CYC*BLANK_MS`
  - `DWELL_CYC = MS_CYC*DWELL_MS`
  - Counter widths use `$clog2` of (constant + 1).
- Input synchronisers: `sw` and `key_n` each pass through a 2-FF synchroniser.
- Key debounce:
  - The debounced level updates only after the synced level has differed from it for DB_CYC consecutive cycles.
  - Any bounce restarts the count.
  - A debounced 1→0 edge gives `key_press`, a one-cycle pulse.
  - Each `key_press` toggles `auto_on`.
- Target mode:
  - Manual (`auto_on`=0): target = `sw_sync`.
  - Auto: target = `cur_mode`+1 (3 wraps to 0), and it is requested only when the dwell counter reaches DWELL_CYC-1.
- FSM states: RUN, BLANK, LOAD.
- RUN:
  - `led_out` <= `pat[cur_mode]`.
  - `eng_en` = onehot(`cur_mode`).
  - The dwell counter increments while `auto_on`=1 and clears otherwise.
  - A switch request occurs if, manual, target != `cur_mode`, or, auto, dwell expiry.
  - On a request: latch `nxt_mode`, `eng_en` <= 0, `led_out` <= 0, blank counter <= 0, go to BLANK.
- BLANK:
  - `led_out` = 0 and `eng_en` = 0.
  - Lasts exactly BLANK_CYC cycles.
  - On the last cycle: `eng_clr` <= onehot(`nxt_mode`) for one cycle, `cur_mode` <= `nxt_mode`, go to LOAD.
- LOAD (one cycle): `eng_en` <= onehot(`cur_mode`), dwell counter <= 0, go to RUN.
- `busy` = (state != RUN).
- Boundary cases:
  - `sw` changes during BLANK/LOAD: `nxt_mode` is not updated. RUN re-evaluates on its first cycle and starts a new switch if the target still differs.
  - `key_press` during BLANK/LOAD: `auto_on` toggles immediately. The in-flight switch completes. A dwell is counted only from LOAD.
  - Leaving auto while `sw` != `cur_mode`: the switch starts on the next RUN cycle.
  - `sw` equal to `cur_mode`: no action and no blank.
- Reset mid-operation: every state is cleared at once, with no completion of BLANK.

## Timing
- Reset values:
  - state = RUN, `cur_mode` = 0, `eng_en` = 4'b0001, `eng_clr` = 0, `led_out` = 0, `auto_on` = 0, `busy` = 0.
  - All counters = 0. Debounced key level = 1. Synchronisers = 1 for `key_n` and 0 for `sw`.
- `led_out` follows `pat[cur_mode]` with 1 cycle of latency in RUN.
- `sw` edge to `led_out` = 0: 3 cycles (2 sync + 1 register).
- Switch cost: BLANK_CYC + 1 cycles from the first dark cycle to the first `led_out` = `pat[nxt]` cycle. `eng_clr` precedes `eng_en` by 1 cycle.
- Auto period: DWELL_CYC + BLANK_CYC + 1 cycles per mode.
- Debounce: first stable sample to `key_press` = DB_CYC + 2 cycles.

## Structure
- Shared package `led_pkg`:
  - Mode encodings MODE_OFF = 0, MODE_BREATH = 1, MODE_HORSE = 2, MODE_BLINK = 3.
  - FSM state encodings.
  - `onehot4` function.
- One sub-module, `key_debounce`: synchroniser, stable counter, press pulse; parameter `DB_CYC`.
- The pattern engines stay outside. `led_ctrl` instantiates this block alongside `u_led_breath` and `u_led_horse`.

## Test plan
All scenarios use CLK_FREQ = 50_000 (MS_CYC = 50), BLANK_MS = 10 (500 cycles), DWELL_MS = 100 (5000 cycles), DEBOUNCE_MS = 20 (1000 cycles).

- Reset, then `sw` = 0 with `pat0` = 8'h00 → `led_out` = 0, `eng_en` = 0001, `busy` = 0, and it stays so.
- `sw` 0→2 with `pat2` = 8'hA5 → `led_out` = 0 at +3 cycles; `eng_clr` = 0100 for one cycle at +502; `eng_en` = 0100 at +503; `led_out` = 8'hA5 at +504.
- `sw` 2→1→2 within the BLANK window → the switch to 1 completes, then exactly one further switch to 2; `eng_clr` pulses 0010, then 0100.
- `key_n` bounces 5× at 100-cycle spacing, then holds low 1200 cycles → exactly one `key_press`, `auto_on` = 1; `cur_mode` steps 0→1→2→3→0 every 5501 cycles.
- `key_n` held low for only 800 cycles → no `key_press`, `auto_on` unchanged.
- `rst_n` asserted mid-BLANK, then released with `sw` = 3 → outputs at reset values immediately; the switch to mode 3 starts 3 cycles after release.
